// File: rtl/le18_access_ctrl.sv
// le18_access_ctrl: Z80 port decoder, cursor auto-increment and whole-bitmap fill engine
// sharing port A of the LE18 graphics RAM. The fill engine is built only when LE18_FILL_EN is defined.
module le18_access_ctrl (
   input  logic        clk,
   input  logic        srst,
   input  logic [7:0]  TRS_A,
   input  logic [7:0]  TRS_D,
   input  logic        TRS_OUT,
   input  logic        TRS_IN,
   input  logic        io_access,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [13:0] ram_addr,
   output logic [5:0]  ram_din,
   output logic        ram_oce,
   input  logic [5:0]  ram_dout,
   output logic [7:0]  dout,
   output logic        dout_rdy,
   output logic        busy
);

   localparam logic [7:0]  PORT_DATA = 8'hEC;
   localparam logic [7:0]  PORT_X    = 8'hED;
   localparam logic [7:0]  PORT_Y    = 8'hEE;
   localparam logic [7:0]  PORT_FILL = 8'hEA;
   localparam logic [7:0]  PORT_CTRL = 8'hEB;
   localparam logic [7:0]  Y_LAST    = 8'd191;
   localparam logic [13:0] FILL_LAST = 14'd12287;
`ifdef LE18_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   // registered Z80 bus
   logic [7:0] a_q, a_d, d_q, d_d;
   logic       wr_n_q, wr_n_d, rd_n_q, rd_n_d, io_q, io_d, hit_prev_q, hit_prev_d;
   // Z80 RAM slot and read pipeline
   logic       z_ce_q, z_ce_d, z_we_q, z_we_d;
   logic [5:0] z_din_q, z_din_d;
   logic       rd1_q, rd1_d, rd1_ram_q, rd1_ram_d, rd2_q, rd2_d, rd2_ram_q, rd2_ram_d;
   logic       rdy_q, rdy_d, rdy_ram_q, rdy_ram_d;
   // cursor and control
   logic [5:0] x_q, x_d;
   logic [7:0] y_q, y_d;
   logic       ax_q, ax_d, ay_q, ay_d;

   logic        wr_port, rd_port, hit, evt, ev_wr, ev_rd;
   logic [7:0]  y_inc;
   logic        fill_we, busy_int;
   logic [13:0] fill_addr;
   logic [5:0]  fill_din;

   // NOTE: all port strobes fold into one hit term, so a held access yields exactly one event.
   always_comb begin
      wr_port = (a_q == PORT_DATA) || (a_q == PORT_X) || (a_q == PORT_Y) ||
                (a_q == PORT_CTRL) || (FILL_EN && (a_q == PORT_FILL));
      rd_port = (a_q == PORT_DATA) || (a_q == PORT_CTRL);
      hit     = io_q && ((!wr_n_q && wr_port) || (!rd_n_q && rd_port));
      evt     = hit && !hit_prev_q;
      ev_wr   = evt && !wr_n_q && wr_port;
      ev_rd   = evt && !rd_n_q && rd_port && !ev_wr;
      y_inc   = (y_q == Y_LAST) ? 8'd0 : y_q + 8'd1;
   end

   always_comb begin
      a_d        = TRS_A;
      d_d        = TRS_D;
      wr_n_d     = TRS_OUT;
      rd_n_d     = TRS_IN;
      io_d       = io_access;
      hit_prev_d = hit;
      z_ce_d     = (ev_wr || ev_rd) && (a_q == PORT_DATA);
      z_we_d     = ev_wr;
      z_din_d    = d_q[5:0];
      rd1_d      = ev_rd;
      rd1_ram_d  = ev_rd && (a_q == PORT_DATA);
      rd2_d      = rd1_q;
      rd2_ram_d  = rd1_ram_q;
      rdy_d      = rd2_q;
      rdy_ram_d  = rd2_ram_q;
      x_d        = x_q;
      y_d        = y_q;
      ax_d       = ax_q;
      ay_d       = ay_q;
      // auto-increment follows the RAM slot; a cursor port write in the same cycle overrides it
      if (z_ce_q) begin
         if (ax_q) begin
            x_d = x_q + 6'd1;
            if (ay_q && (x_q == 6'd63)) y_d = y_inc;
         end else if (ay_q) begin
            y_d = y_inc;
         end
      end
      if (ev_wr) begin
         case (a_q)
            PORT_X:    x_d = d_q[5:0];
            PORT_Y:    y_d = d_q;
            PORT_CTRL: begin
               ax_d = d_q[0];
               ay_d = d_q[1];
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignment only; every flop clears on srst.
   always_ff @(posedge clk) begin
      if (srst) begin
         a_q <= '0;  d_q <= '0;  wr_n_q <= 1'b1;  rd_n_q <= 1'b1;  io_q <= 1'b0;
         hit_prev_q <= 1'b0;
         z_ce_q <= 1'b0;  z_we_q <= 1'b0;  z_din_q <= '0;
         rd1_q <= 1'b0;  rd1_ram_q <= 1'b0;  rd2_q <= 1'b0;  rd2_ram_q <= 1'b0;
         rdy_q <= 1'b0;  rdy_ram_q <= 1'b0;
         x_q <= '0;  y_q <= '0;  ax_q <= 1'b0;  ay_q <= 1'b0;
      end else begin
         a_q <= a_d;  d_q <= d_d;  wr_n_q <= wr_n_d;  rd_n_q <= rd_n_d;  io_q <= io_d;
         hit_prev_q <= hit_prev_d;
         z_ce_q <= z_ce_d;  z_we_q <= z_we_d;  z_din_q <= z_din_d;
         rd1_q <= rd1_d;  rd1_ram_q <= rd1_ram_d;  rd2_q <= rd2_d;  rd2_ram_q <= rd2_ram_d;
         rdy_q <= rdy_d;  rdy_ram_q <= rdy_ram_d;
         x_q <= x_d;  y_q <= y_d;  ax_q <= ax_d;  ay_q <= ay_d;
      end
   end

`ifdef LE18_FILL_EN
   typedef enum logic {S_IDLE, S_FILL} fill_state_e;

   fill_state_e state_q, state_d;
   logic [13:0] cnt_q, cnt_d;
   logic [5:0]  fill_val_q, fill_val_d;
   logic        arm_q, arm_d;

   // arm_q holds off the first write so a fill begins driving RAM two cycles after its event
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fill_val_d = fill_val_q;
      arm_d      = 1'b0;
      fill_we    = (state_q == S_FILL) && !arm_q && !z_ce_q;
      if (fill_we) begin
         cnt_d = cnt_q + 14'd1;
         if (cnt_q == FILL_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      end
      if (ev_wr && (a_q == PORT_FILL)) fill_val_d = d_q[5:0];
      if (ev_wr && (a_q == PORT_CTRL) && d_q[7]) begin
         state_d = S_FILL;
         cnt_d   = '0;
         arm_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         fill_val_q <= '0;
         arm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fill_val_q <= fill_val_d;
         arm_q      <= arm_d;
      end
   end

   assign fill_addr = cnt_q;
   assign fill_din  = fill_val_q;
   assign busy_int  = (state_q == S_FILL);
`else
   assign fill_we   = 1'b0;
   assign fill_addr = '0;
   assign fill_din  = '0;
   assign busy_int  = 1'b0;
`endif

   // dout is gated by the ready flop so it sits at zero outside its valid cycle
   always_comb begin
      ram_ce   = z_ce_q || fill_we;
      ram_we   = z_ce_q ? z_we_q : fill_we;
      ram_addr = fill_we ? fill_addr : {y_q, x_q};
      ram_din  = fill_we ? fill_din : z_din_q;
      ram_oce  = rd2_ram_q;
      dout_rdy = rdy_q;
      busy     = busy_int;
      dout     = 8'h00;
      if (rdy_q) dout = rdy_ram_q ? {2'b00, ram_dout} : {busy_int, 5'b00000, ay_q, ax_q};
   end

endmodule

// File: tb/tb_le18_access_ctrl.sv
// Directed bench for le18_access_ctrl: cursor writes, auto-increment wraps, read latency,
// status, and (with LE18_FILL_EN) fill sequencing, Z80 priority and reset abort.
module tb_le18_access_ctrl;

   logic        clk = 1'b0;
   logic        srst;
   logic [7:0]  TRS_A, TRS_D;
   logic        TRS_OUT, TRS_IN, io_access;
   logic        ram_ce, ram_we, ram_oce, dout_rdy, busy;
   logic [13:0] ram_addr;
   logic [5:0]  ram_din;
   logic [5:0]  ram_dout = 6'h00;
   logic [7:0]  dout;

   int n_vec = 0;
   int n_err = 0;

   logic        cap_ce [5];
   logic        cap_we [5];
   logic        cap_oce [5];
   logic        cap_rdy [5];
   logic        cap_busy [5];
   logic [13:0] cap_addr [5];
   logic [5:0]  cap_din [5];
   logic [7:0]  cap_dout [5];

   le18_access_ctrl dut (
      .clk(clk), .srst(srst), .TRS_A(TRS_A), .TRS_D(TRS_D), .TRS_OUT(TRS_OUT),
      .TRS_IN(TRS_IN), .io_access(io_access), .ram_ce(ram_ce), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_oce(ram_oce), .ram_dout(ram_dout),
      .dout(dout), .dout_rdy(dout_rdy), .busy(busy)
   );

   always #5 clk = ~clk;

   // port-A RAM with an output register: data appears the cycle after ram_oce
   logic [5:0] mem [16384];
   logic [5:0] mem_rd_q = 6'h00;
   initial for (int i = 0; i < 16384; i++) mem[i] = 6'h00;
   always @(posedge clk) begin
      if (ram_ce && ram_we) mem[ram_addr] <= ram_din;
      if (ram_ce && !ram_we) mem_rd_q <= mem[ram_addr];
      if (ram_oce) ram_dout <= mem_rd_q;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One Z80 access held for three cycles; captures outputs at event cycle N .. N+4.
   task automatic access(input logic [7:0] a, input logic [7:0] d, input bit wr);
      TRS_A = a;
      TRS_D = d;
      io_access = 1'b1;
      if (wr) TRS_OUT = 1'b0;
      else TRS_IN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cap_ce[i] = ram_ce;     cap_we[i] = ram_we;     cap_oce[i] = ram_oce;
         cap_rdy[i] = dout_rdy;  cap_busy[i] = busy;     cap_addr[i] = ram_addr;
         cap_din[i] = ram_din;   cap_dout[i] = dout;
         if (i == 2) begin
            TRS_OUT = 1'b1;
            TRS_IN = 1'b1;
            io_access = 1'b0;
         end
      end
      @(negedge clk);
   endtask

`ifdef LE18_FILL_EN
   // mode 0: plain fill; 1: Z80 write lands on counter 100; 2: srst at counter 500
   task automatic run_fill(input int mode);
      int nwr = 0, nxt = 0, seq_err = 0, hi = 0, first_k = -1, last_k = -1;
      int set_k = -100, done_k = -1, post_wr = 0;
      bit finished = 1'b0;
      TRS_A = 8'hEB;
      TRS_D = 8'h80;
      io_access = 1'b1;
      TRS_OUT = 1'b0;
      for (int k = 0; k < 20000 && !finished; k++) begin
         @(negedge clk);
         if (k == 0) check("fill_busy_at_n", busy, 0);
         if (k == 1) check("fill_busy_at_n1", busy, 1);
         if (k == 3 || k == set_k + 4) begin
            TRS_OUT = 1'b1;
            io_access = 1'b0;
         end
         if (mode == 1 && k == set_k + 2) begin
            check("z80_slot_we", {31'd0, ram_ce & ram_we}, 1);
            check("z80_slot_addr", ram_addr, 14'h00C7);
            check("z80_slot_din", ram_din, 6'h2A);
         end else if (mode == 2 && set_k >= 0) begin
            if (k == set_k + 1) begin
               check("rst_busy", busy, 0);
               check("rst_ram_ce", ram_ce, 0);
               srst = 1'b0;
            end
            if (ram_ce) post_wr++;
            if (k == set_k + 4) finished = 1'b1;
         end else if (ram_ce && ram_we) begin
            if (ram_addr != nxt[13:0] || ram_din != 6'h3F) seq_err++;
            if (ram_addr > 14'd12287) hi++;
            if (first_k < 0) first_k = k;
            last_k = k;
            nwr++;
            nxt++;
            if (mode == 1 && set_k < 0 && ram_addr == 14'd98) begin
               TRS_A = 8'hEC;
               TRS_D = 8'h2A;
               TRS_OUT = 1'b0;
               io_access = 1'b1;
               set_k = k;
            end
            if (mode == 2 && ram_addr == 14'd499) begin
               srst = 1'b1;
               set_k = k;
            end
         end
         if (mode != 2 && k > 1 && !busy && done_k < 0) done_k = k;
         if (done_k >= 0 && k == done_k + 3) finished = 1'b1;
      end
      check("fill_finished", {31'd0, finished}, 1);
      if (mode != 2) begin
         check("fill_writes", nwr, 12288);
         check("fill_seq_err", seq_err, 0);
         check("fill_over_top", hi, 0);
         check("fill_first_cycle", first_k, 2);
         check("fill_span", last_k - first_k + 1, (mode == 1) ? 12289 : 12288);
         check("fill_busy_drop", done_k, last_k + 1);
      end else begin
         check("rst_writes_before", nwr, 500);
         check("rst_seq_err", seq_err, 0);
         check("rst_writes_after", post_wr, 0);
      end
      TRS_OUT = 1'b1;
      io_access = 1'b0;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      srst = 1'b1;
      TRS_A = 8'h00;
      TRS_D = 8'h00;
      TRS_OUT = 1'b1;
      TRS_IN = 1'b1;
      io_access = 1'b0;
      repeat (3) @(negedge clk);
      srst = 1'b0;
      @(negedge clk);
      check("rst_ram_ce", ram_ce, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_oce", ram_oce, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_dout", dout, 0);
      check("rst_dout_rdy", dout_rdy, 0);
      check("rst_busy", busy, 0);

      // single data write at {y=10, x=5}
      access(8'hED, 8'd5, 1'b1);
      access(8'hEE, 8'd10, 1'b1);
      access(8'hEC, 8'h2A, 1'b1);
      check("wr_ce_n", cap_ce[0], 0);
      check("wr_ce_n1", cap_ce[1], 1);
      check("wr_we_n1", cap_we[1], 1);
      check("wr_addr", cap_addr[1], 14'h0285);
      check("wr_din", cap_din[1], 6'h2A);
      check("wr_ce_n2", cap_ce[2], 0);
      access(8'hEC, 8'h11, 1'b1);
      check("wr_no_inc", cap_addr[1], 14'h0285);

      // AX & AY wrap from the last pixel
      access(8'hEB, 8'h03, 1'b1);
      access(8'hED, 8'd63, 1'b1);
      access(8'hEE, 8'd191, 1'b1);
      access(8'hEC, 8'h01, 1'b1);
      check("axy_addr0", cap_addr[1], 14'h2FFF);
      access(8'hEC, 8'h02, 1'b1);
      check("axy_addr1", cap_addr[1], 14'h0000);
      access(8'hEC, 8'h03, 1'b1);
      check("axy_addr2", cap_addr[1], 14'h0001);

      // AY only wraps 191 -> 0
      access(8'hEB, 8'h02, 1'b1);
      access(8'hED, 8'd0, 1'b1);
      access(8'hEE, 8'd191, 1'b1);
      access(8'hEC, 8'h04, 1'b1);
      check("ay_addr0", cap_addr[1], 14'h2FC0);
      access(8'hEC, 8'h05, 1'b1);
      check("ay_addr1", cap_addr[1], 14'h0000);

      // AX only: x wraps, y untouched
      access(8'hEB, 8'h01, 1'b1);
      access(8'hED, 8'd63, 1'b1);
      access(8'hEE, 8'd5, 1'b1);
      access(8'hEC, 8'h06, 1'b1);
      check("ax_addr0", cap_addr[1], 14'h017F);
      access(8'hEC, 8'h07, 1'b1);
      check("ax_addr1", cap_addr[1], 14'h0140);

      // Y beyond the visible range is kept as written
      access(8'hEB, 8'h00, 1'b1);
      access(8'hEE, 8'd200, 1'b1);
      access(8'hED, 8'd2, 1'b1);
      access(8'hEC, 8'h08, 1'b1);
      check("yhi_addr", cap_addr[1], 14'h3202);

      // data read latency
      access(8'hED, 8'd0, 1'b1);
      access(8'hEE, 8'd1, 1'b1);
      access(8'hEC, 8'h15, 1'b1);
      access(8'hEC, 8'h00, 1'b0);
      check("rd_ce_n1", cap_ce[1], 1);
      check("rd_we_n1", cap_we[1], 0);
      check("rd_addr", cap_addr[1], 14'h0040);
      check("rd_oce_n1", cap_oce[1], 0);
      check("rd_oce_n2", cap_oce[2], 1);
      check("rd_rdy_n2", cap_rdy[2], 0);
      check("rd_rdy_n3", cap_rdy[3], 1);
      check("rd_dout", cap_dout[3], 8'h15);
      check("rd_rdy_n4", cap_rdy[4], 0);

      // status read
      access(8'hEB, 8'h03, 1'b1);
      access(8'hEB, 8'h00, 1'b0);
      check("st_ce", cap_ce[1], 0);
      check("st_rdy_n3", cap_rdy[3], 1);
      check("st_dout", cap_dout[3], 8'h03);

      access(8'hEA, 8'h3F, 1'b1);
`ifdef LE18_FILL_EN
      run_fill(0);
      access(8'hED, 8'd7, 1'b1);
      access(8'hEE, 8'd3, 1'b1);
      run_fill(1);
      run_fill(2);
      access(8'hEB, 8'h00, 1'b0);
      check("rst_st_rdy", cap_rdy[3], 1);
      check("rst_st_dout", cap_dout[3], 8'h00);
`else
      access(8'hEB, 8'h80, 1'b1);
      check("nofill_busy", cap_busy[1], 0);
      check("nofill_ce", cap_ce[2], 0);
      access(8'hEB, 8'h00, 1'b0);
      check("nofill_st_dout", cap_dout[3], 8'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/le18_access_ctrl.md
# le18_access_ctrl

Z80-side access controller for the LE18 6-bit graphics RAM (port A of the 64x192 pixel-column store). It decodes the LE18 I/O ports, converts each Z80 port access into one RAM cycle, and auto-increments the X/Y cursor after each data access. It also runs a hardware fill engine that clears or fills the whole bitmap. Z80 and fill traffic are arbitrated onto the single RAM port, with the Z80 always taking priority.

## Interface
- No parameters.
- clk  in  1  system clock.
- srst  in  1  reset: synchronous, active-high; clears all state in the cycle it is sampled.
- TRS_A  in  8  Z80 I/O port address (low byte).
- TRS_D  in  8  Z80 data bus.
- TRS_OUT  in  1  active-low I/O write strobe.
- TRS_IN  in  1  active-low I/O read strobe.
- io_access  in  1  bus cycle qualifier; held for a multi-cycle Z80 access.
- ram_ce  out  1  RAM port-A clock enable.
- ram_we  out  1  RAM port-A write enable; valid only with ram_ce.
- ram_addr  out  14  {y[7:0], x[5:0]}.
- ram_din  out  6  write data.
- ram_oce  out  1  RAM output-register enable.
- ram_dout  in  6  RAM read data; valid the cycle after ram_oce.
- dout  out  8  read data to the Z80 bus mux.
- dout_rdy  out  1  one-cycle pulse: dout is valid.
- busy  out  1  fill engine active.

## Operation
- Port map:
  - 0xEC data read/write.
  - 0xED X write (D[5:0]).
  - 0xEE Y write (D[7:0]).
  - 0xEA fill value write (D[5:0]).
  - 0xEB control write / status read.
- Control write fields:
  - D[0] = AX, X auto-increment.
  - D[1] = AY, Y auto-increment.
  - D[7] = 1 starts a fill.
- Status read returns {busy, 5'b0, AY, AX}. A data read returns {2'b00, ram_dout}.
- Event detection: an access event is the first cycle in which io_access & port match & strobe is true after a cycle where it was false. Exactly one event is generated per Z80 access.
- Auto-increment is applied once after each 0xEC access, in the cycle after ram_ce:
  - AX only: x = (x+1) mod 64.
  - AY only: y = (y+1) mod 192.
  - AX & AY: x+1; on a 63→0 wrap, y increments, with y wrapping 191→0.
  - Neither: no change.
- Y writes ≥192 are stored as written. RAM locations above 12287 are unused but addressable.
- Fill FSM has two states, IDLE and FILL.
  - IDLE→FILL on a control write with D[7]=1; the fill counter is set to 0 and busy goes to 1.
  - In FILL, each cycle without a Z80 RAM slot drives ram_ce=1, ram_we=1, ram_addr=counter, ram_din=fill value, then increments the counter.
  - After writing address 12287, the FSM goes FILL→IDLE and busy goes to 0.
  - A D[7]=1 write while in FILL restarts the fill from address 0.
- The fill counter is independent of x/y. Cursor writes during a fill do not disturb it.
- Arbitration: when a Z80 RAM cycle and a fill write fall in the same cycle, the Z80 cycle wins. The fill stalls that cycle and does not advance its counter.
- A fill-value write during FILL takes effect on the next fill write.

## Timing
- Event at cycle N (detected from registered inputs).
- Data write: ram_ce = ram_we = 1 at N+1 with addr {y, x}; auto-increment at N+2.
- Data read:
  - ram_ce=1, ram_we=0 at N+1.
  - ram_oce=1 at N+2.
  - dout valid and dout_rdy=1 at N+3.
  - Auto-increment at N+2.
- Status read: dout_rdy at N+3, so all reads have uniform latency.
- Register writes (X, Y, fill value, control) take effect at N+1. The fill starts driving RAM at N+2.
- If a cursor port write coincides with auto-increment, the port write wins.
- Reset values: x=0, y=0, AX=AY=0, fill value=0, counter=0, state IDLE.
  - Outputs after reset: ram_ce=0, ram_we=0, ram_oce=0, ram_addr=0, ram_din=0, dout=0, dout_rdy=0, busy=0.
- srst during a fill aborts it immediately. No further writes occur.
- srst during a read pipeline cancels the pending dout_rdy.

## Configuration
- LE18_FILL_EN defined: fill engine, port 0xEA, and control D[7] are compiled in.
- LE18_FILL_EN undefined:
  - No fill logic.
  - 0xEA writes are ignored; D[7] is ignored.
  - busy is tied to 0; the status bit 7 reads 0.
  - ram_ce/ram_we are driven only by Z80 events.

## Test plan
- Reset, X=5, Y=10, write 0x2A to 0xEC → one ram_ce/ram_we cycle at N+1 with addr 0x0285 and din 0x2A; x/y unchanged.
- Control=0x03, X=63, Y=191, two data writes → addrs 0x2FFF then 0x0000; final x=1, y=0.
- Preload addr 0x0040 with 0x15, read 0xEC → ram_oce at N+2; dout=0x15 and one dout_rdy pulse at N+3.
- Fill value 0x3F, control=0x80 → busy=1, 12288 sequential writes 0..12287 of 0x3F, busy=0 after the last write, no write to 12288.
- Z80 data write mid-fill at counter 100 → Z80 addr wins that cycle; fill resumes at 100 with no skipped address; total fill length is 12289 cycles.
- srst asserted at fill counter 500 → busy=0 and ram_ce=0 on the next cycle; a status read returns 0x00.
